fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage: owns the program counter, drives PC into the
//   byte-addressed instruction ROM and captures the returned little-endian
//   word into the IF/ID pipeline register for decode.
//   - Handles sequential fetch, branch/jump redirects, decode back-pressure
//     (stall) and halt.
//   - Sits directly upstream of the instruction memory and feeds decode.
// PARAMETERS
//   ADDRESS_WIDTH  16   width of PC and of all address ports (byte address)
//   DATA_WIDTH     32   instruction width
//   RESET_PC       0    first fetch address after reset; word-aligned
// PORTS
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous, active-high reset
//   stall         in   1   decode not ready; hold PC and IF/ID register
//   redirect      in   1   taken branch/jump from execute
//   redirect_pc   in   AW  redirect target byte address
//   halt          in   1   stop fetching (e.g. ecall/ebreak decoded)
//   instr         in   DW  word from instr ROM, combinational on PC
//   PC            out  AW  fetch address to instr ROM (registered)
//   id_instr      out  DW  IF/ID instruction
//   id_pc         out  AW  IF/ID address of id_instr
//   id_pc_plus4   out  AW  id_pc + 4, modulo 2^AW
//   id_valid      out  1   id_instr is a real instruction
//   misalign_err  out  1   sticky: misaligned redirect seen
//   fetch_halted  out  1   FSM is in HALT
// BEHAVIOUR
//   Reset values (asynchronous, while rst=1):
//     PC=RESET_PC, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc_plus4=0,
//     id_valid=0, misalign_err=0, fetch_halted=0, state=BOOT.
//   FSM states: BOOT, RUN, HALT.
//   BOOT: lasts one cycle.
//     - PC=RESET_PC, id_valid=0; all inputs ignored.
//     - Next state is RUN. PC is not advanced, so the first RUN cycle
//       fetches RESET_PC.
//   RUN, priority order per cycle (highest first):
//     1 halt=1: next state HALT, id_valid<=0, PC held. Halt wins over
//       redirect and stall.
//     2 redirect=1 and redirect_pc[1:0]!=0: misalign_err<=1, next state
//       HALT, id_valid<=0, PC held.
//     3 redirect=1 (aligned): PC<=redirect_pc, id_instr<=NOP,
//       id_valid<=0 (flush the wrong-path word).
//       - Redirect overrides stall.
//       - id_pc and id_pc_plus4 are held.
//     4 stall=1: PC, id_instr, id_pc, id_pc_plus4 and id_valid all held.
//     5 otherwise: id_instr<=instr, id_pc<=PC, id_pc_plus4<=PC+4,
//       id_valid<=1, PC<=PC+4.
//   HALT: terminal until rst.
//     - PC held, id_valid=0, fetch_halted=1.
//     - stall, redirect and halt are ignored.
//   Latency: the word at address A is on id_instr exactly one clock edge
//     after PC=A, provided there is no stall, redirect or halt in that cycle.
//   Arithmetic: PC+4 wraps modulo 2^ADDRESS_WIDTH, so 0xFFFC -> 0x0000 for
//     AW=16. No overflow flag.
//   misalign_err is sticky and is cleared only by rst.
//   Reset mid-operation: all registers return to their reset values
//     immediately (asynchronously); the BOOT cycle follows deassertion.
//   RESET_PC misaligned is a configuration error; no runtime check.
// TESTING
//   1 Reset release, ROM bytes 0..11 = 13 00 00 00 / 93 00 10 00 /
//     13 01 20 00 -> BOOT for one cycle with id_valid=0, then
//     id_instr=0x00000013, 0x00100093, 0x00200113 on consecutive cycles;
//     id_pc=0,4,8; id_pc_plus4=4,8,12.
//   2 stall held for 3 cycles at PC=8 -> PC stays 8; IF/ID frozen with
//     id_pc=4 and id_valid=1; resumes with id_pc=8 on the cycle after
//     stall drops.
//   3 redirect=1, redirect_pc=0x0040, with stall=1 in the same cycle ->
//     next cycle PC=0x40, id_valid=0, id_instr=NOP; following cycle
//     id_pc=0x40, id_valid=1.
//   4 redirect_pc=0x0042 -> misalign_err=1, fetch_halted=1, PC frozen; a
//     later aligned redirect is ignored; rst clears everything.
//   5 halt and redirect asserted together -> HALT entered, PC unchanged,
//     id_valid=0.
//   6 redirect to 0xFFFC (AW=16), no stall -> next two fetches at PC=0xFFFC
//     then 0x0000; id_pc_plus4=0x0000 while id_pc=0xFFFC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the program counter, presents it
// to a combinational byte-addressed instruction ROM, and captures the returned
// word into the IF/ID register for decode.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   stall          decode back-pressure: hold PC and IF/ID
//   redirect       taken branch/jump, target on redirect_pc
//   halt           stop fetching; terminal until reset
//   instr          ROM word at PC
//   PC             registered fetch address
//   id_instr/id_pc/id_pc_plus4/id_valid   IF/ID register contents
//   misalign_err   sticky flag for a misaligned redirect target
//   fetch_halted   stage is in its terminal halt state
module fetch_stage #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     halt,
  input  logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0]    id_instr,
  output logic [ADDRESS_WIDTH-1:0] id_pc,
  output logic [ADDRESS_WIDTH-1:0] id_pc_plus4,
  output logic                     id_valid,
  output logic                     misalign_err,
  output logic                     fetch_halted
);

  localparam logic [DATA_WIDTH-1:0]    NOP      = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP  = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]      id_instr_q, id_instr_d;
  logic [ADDRESS_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [ADDRESS_WIDTH-1:0]   id_pc_plus4_q, id_pc_plus4_d;
  logic                       id_valid_q, id_valid_d;
  logic                       err_q, err_d;
  logic                       halted_q, halted_d;
  logic [ADDRESS_WIDTH-1:0]   pc_plus4;

  // Sequential successor; wraps modulo 2^ADDRESS_WIDTH.
  assign pc_plus4 = pc_q + PC_STEP;

  // State and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      id_instr_q    <= NOP;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_valid_q    <= 1'b0;
      err_q         <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      err_q         <= err_d;
      halted_q      <= halted_d;
    end
  end

  // Next-state logic; RUN applies halt > misaligned redirect > redirect > stall > fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    err_d         = err_q;

    case (state_q)
      S_BOOT: begin
        state_d    = S_RUN;
        pc_d       = RESET_PC;
        id_valid_d = 1'b0;
      end
      S_RUN: begin
        if (halt) begin
          state_d    = S_HALT;
          id_valid_d = 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
          err_d      = 1'b1;
          state_d    = S_HALT;
          id_valid_d = 1'b0;
        end else if (redirect) begin
          // Flush the wrong-path word; id_pc/id_pc_plus4 keep their old values.
          pc_d       = redirect_pc;
          id_instr_d = NOP;
          id_valid_d = 1'b0;
        end else if (!stall) begin
          id_instr_d    = instr;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_plus4;
          id_valid_d    = 1'b1;
          pc_d          = pc_plus4;
        end
      end
      S_HALT: begin
        id_valid_d = 1'b0;
      end
      default: begin
        state_d    = S_BOOT;
        id_valid_d = 1'b0;
      end
    endcase

    halted_d = (state_d == S_HALT);
  end

  assign PC           = pc_q;
  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign id_pc_plus4  = id_pc_plus4_q;
  assign id_valid     = id_valid_q;
  assign misalign_err = err_q;
  assign fetch_halted = halted_q;

endmodule
